bcd_serial_converter: RTL and testbench

BCD_SERIAL_CONVERTER -- requirements
Module: bcd_serial_converter

---
 rtl/bcd_serial_converter.sv | 158 +++++++++++++++
 tb/tb_bcd_serial_converter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_converter.sv
// Purpose : serial binary-to-BCD converter (shift-and-add-3), one bit per CONV cycle.
// Latency : start accepted at edge k -> result on bcd after edge k+BIN_W, done high after edge k+BIN_W+1.
// Backpr. : none; start is ignored while converting, a start seen in DONE chains the next conversion.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - request a conversion of binary (accepted in IDLE or DONE)
//   binary     - unsigned value, sampled only on an accepted start
//   busy       - high while a conversion is shifting (registered)
//   done       - one-cycle pulse once the new result is published (registered)
//   bcd        - packed digits, digit 0 (ones) in bits [3:0]
//   overflow   - the published value did not fit in DIGITS digits
//   lead_blank - bit i (i>=1) set when digit i and every higher digit are zero
module bcd_serial_converter #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lead_blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [DIGITS-1:0] LB_ONE    = DIGITS'(1);
    localparam logic [DIGITS-1:0] LB_RST    = ~LB_ONE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [BIN_W-1:0]    shreg_q,      shreg_d;
    logic [BCD_W-1:0]    scratch_q,    scratch_d;
    logic                ovf_q,        ovf_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic [BCD_W-1:0]    bcd_q,        bcd_d;
    logic                overflow_q,   overflow_d;
    logic [DIGITS-1:0]   lead_blank_q, lead_blank_d;

    logic [BCD_W-1:0]    adj;

    // Bit i is set when digits i..DIGITS-1 are all zero; the ones digit is
    // always shown, so bit 0 stays clear.
    function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] b;
        logic              zero_above;
        b          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[4*i +: 4] == 4'd0);
            b[i]       = zero_above;
        end
        return b;
    endfunction

    // Add-3 correction on every digit in parallel, ahead of the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        scratch_d    = scratch_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        overflow_d   = overflow_q;
        lead_blank_d = lead_blank_q;
        // Status outputs are a registered decode of the current state, so they
        // trail the state by one cycle: done appears once bcd is already stable.
        busy_d       = (state_q == S_CONV);
        done_d       = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CONV;
                    shreg_d   = binary;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CONV: begin
                // Shift {scratch, shreg} left by one; the bit leaving the top
                // digit is worth 10^DIGITS, so dropping it leaves value mod 10^DIGITS.
                scratch_d = {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
                ovf_d     = ovf_q | adj[BCD_W-1];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d      = S_DONE;
                    bcd_d        = scratch_d;
                    overflow_d   = ovf_d;
                    lead_blank_d = blank_of(scratch_d);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            scratch_q    <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bcd_q        <= '0;
            overflow_q   <= 1'b0;
            lead_blank_q <= LB_RST;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            scratch_q    <= scratch_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bcd_q        <= bcd_d;
            overflow_q   <= overflow_d;
            lead_blank_q <= lead_blank_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bcd        = bcd_q;
    assign overflow   = overflow_q;
    assign lead_blank = lead_blank_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Bench for bcd_serial_converter: three instances (16/5, 16/4, 8/3) sharing
// clock and reset, driven and sampled on the falling edge.
module tb_bcd_serial_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [31:0] bin_v [3];

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        ovf0, ovf1, ovf2;
    logic [19:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic [4:0]  lb0;
    logic [3:0]  lb1;
    logic [2:0]  lb2;

    bcd_serial_converter #(.BIN_W(16), .DIGITS(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .binary(bin_v[0][15:0]),
        .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0), .lead_blank(lb0));
    bcd_serial_converter #(.BIN_W(16), .DIGITS(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .binary(bin_v[1][15:0]),
        .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1), .lead_blank(lb1));
    bcd_serial_converter #(.BIN_W(8), .DIGITS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .binary(bin_v[2][7:0]),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2), .lead_blank(lb2));

    logic [2:0]  busy_o, done_o, ovf_o;
    logic [39:0] bcd_o [3];
    logic [9:0]  lb_o  [3];

    always_comb begin
        busy_o   = {busy2, busy1, busy0};
        done_o   = {done2, done1, done0};
        ovf_o    = {ovf2, ovf1, ovf0};
        bcd_o[0] = {20'd0, bcd0};
        bcd_o[1] = {24'd0, bcd1};
        bcd_o[2] = {28'd0, bcd2};
        lb_o[0]  = {5'd0, lb0};
        lb_o[1]  = {6'd0, lb1};
        lb_o[2]  = {7'd0, lb2};
    end

    int bw [3] = '{16, 16, 8};
    int dg [3] = '{5, 4, 3};

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic longint pow10(int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [39:0] ref_bcd(longint v, int d);
        logic [39:0] r = '0;
        longint x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(longint v, int d);
        return v >= pow10(d);
    endfunction

    function automatic logic [9:0] ref_lb(longint v, int d);
        logic [9:0] b = '0;
        longint m = v % pow10(d);
        for (int i = 1; i < d; i++) b[i] = (m < pow10(i));
        return b;
    endfunction

    function automatic logic [31:0] width_mask(int u);
        return (32'h1 << bw[u]) - 32'h1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [9:0] lb_exp;
        rst_n   = 1'b0;
        start_v = '0;
        for (int u = 0; u < 3; u++) bin_v[u] = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            lb_exp = ref_lb(0, dg[u]);
            checks++; if (busy_o[u] !== 1'b0) begin errors++; $display("FAIL reset_busy u%0d: got %b want 0", u, busy_o[u]); end
            checks++; if (done_o[u] !== 1'b0) begin errors++; $display("FAIL reset_done u%0d: got %b want 0", u, done_o[u]); end
            checks++; if (bcd_o[u] !== 40'd0) begin errors++; $display("FAIL reset_bcd u%0d: got %h want 0", u, bcd_o[u]); end
            checks++; if (ovf_o[u] !== 1'b0)  begin errors++; $display("FAIL reset_ovf u%0d: got %b want 0", u, ovf_o[u]); end
            checks++; if (lb_o[u] !== lb_exp) begin errors++; $display("FAIL reset_lb u%0d: got %b want %b", u, lb_o[u], lb_exp); end
        end
        rst_n = 1'b1;
    endtask

    // Starts at a falling edge, drives one conversion on unit u and checks
    // timing and result. With noise set, binary and start toggle during CONV.
    task automatic do_conv(int u, logic [31:0] v, bit noise);
        int busy_n = 0, done_n = 0, done_at = -1, both_n = 0;
        logic [39:0] got_bcd = '0, exp_bcd;
        logic        got_ovf = 1'b0, exp_ovf;
        logic [9:0]  got_lb = '0, exp_lb;
        longint      val;
        val     = longint'(v & width_mask(u));
        exp_bcd = ref_bcd(val, dg[u]);
        exp_ovf = ref_ovf(val, dg[u]);
        exp_lb  = ref_lb(val, dg[u]);
        bin_v[u]   = v;
        start_v[u] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < bw[u] + 8; j++) begin
            @(negedge clk);
            if (busy_o[u]) busy_n++;
            if (busy_o[u] && done_o[u]) both_n++;
            if (done_o[u]) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = j;
                    got_bcd = bcd_o[u];
                    got_ovf = ovf_o[u];
                    got_lb  = lb_o[u];
                end
            end
            if (noise && j <= bw[u] - 3) begin
                start_v[u] = 1'($urandom_range(0, 1));
                bin_v[u]   = $urandom;
            end else begin
                start_v[u] = 1'b0;
            end
        end
        checks++; if (done_n != 1)          begin errors++; $display("FAIL done_count u%0d v=%0d: got %0d want 1", u, val, done_n); end
        checks++; if (done_at != bw[u] + 1) begin errors++; $display("FAIL done_latency u%0d v=%0d: got %0d want %0d", u, val, done_at, bw[u] + 1); end
        checks++; if (busy_n != bw[u])      begin errors++; $display("FAIL busy_cycles u%0d v=%0d: got %0d want %0d", u, val, busy_n, bw[u]); end
        checks++; if (both_n != 0)          begin errors++; $display("FAIL busy_and_done u%0d v=%0d: got %0d want 0", u, val, both_n); end
        checks++; if (got_bcd !== exp_bcd)  begin errors++; $display("FAIL bcd u%0d v=%0d: got %h want %h", u, val, got_bcd, exp_bcd); end
        checks++; if (got_ovf !== exp_ovf)  begin errors++; $display("FAIL overflow u%0d v=%0d: got %b want %b", u, val, got_ovf, exp_ovf); end
        checks++; if (got_lb !== exp_lb)    begin errors++; $display("FAIL lead_blank u%0d v=%0d: got %b want %b", u, val, got_lb, exp_lb); end
        checks++; if (bcd_o[u] !== exp_bcd) begin errors++; $display("FAIL bcd_hold u%0d v=%0d: got %h want %h", u, val, bcd_o[u], exp_bcd); end
    endtask

    task automatic test_directed();
        do_conv(0, 32'd65535, 1'b0);
        do_conv(0, 32'd0,     1'b0);
        do_conv(0, 32'd1234,  1'b0);
        do_conv(1, 32'd65535, 1'b0);
        do_conv(1, 32'd9999,  1'b0);
        do_conv(1, 32'd10000, 1'b0);
        do_conv(2, 32'd255,   1'b0);
        do_conv(2, 32'd0,     1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int u = 0; u < 3; u++) begin
                do_conv(u, $urandom, 1'b1);
            end
        end
        do_conv(1, 32'd10000 + $urandom_range(0, 55535), 1'b1);
        do_conv(2, 32'd99 + $urandom_range(0, 156), 1'b1);
    endtask

    // start held high, binary changing every cycle: one accept every BIN_W+1 edges.
    task automatic test_back_to_back();
        logic [31:0] bin_at [0:80];
        logic        exp_done;
        logic [39:0] exp_bcd;
        int          p = bw[0] + 1;
        int          acc;
        start_v[0] = 1'b1;
        bin_v[0]   = $urandom;
        bin_at[0]  = bin_v[0];
        @(posedge clk);
        for (int j = 0; j < 76; j++) begin
            @(negedge clk);
            exp_done = (j > 0) && (j % p == 0) && (j <= 4 * p);
            checks++;
            if (done_o[0] !== exp_done) begin
                errors++; $display("FAIL b2b_done j=%0d: got %b want %b", j, done_o[0], exp_done);
            end
            if (exp_done) begin
                acc     = (j / p - 1) * p;
                exp_bcd = ref_bcd(longint'(bin_at[acc][15:0]), dg[0]);
                checks++;
                if (bcd_o[0] !== exp_bcd) begin
                    errors++; $display("FAIL b2b_bcd j=%0d: got %h want %h", j, bcd_o[0], exp_bcd);
                end
            end
            bin_v[0]      = $urandom;
            bin_at[j + 1] = bin_v[0];
            start_v[0]    = (j + 1 <= 3 * p);
        end
        start_v[0] = 1'b0;
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        bin_v[0]   = 32'd12345;
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (done_o[0]) done_seen++;
            start_v[0] = 1'b0;
            if (j == 8) rst_n = 1'b0;
        end
        @(negedge clk);
        if (done_o[0]) done_seen++;
        checks++; if (done_seen != 0)    begin errors++; $display("FAIL abort_done: got %0d want 0", done_seen); end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o[0]); end
        checks++; if (bcd_o[0] !== 40'd0) begin errors++; $display("FAIL abort_bcd: got %h want 0", bcd_o[0]); end
        checks++; if (ovf_o[0] !== 1'b0)  begin errors++; $display("FAIL abort_ovf: got %b want 0", ovf_o[0]); end
        checks++; if (lb_o[0] !== 10'b0000011110) begin errors++; $display("FAIL abort_lb: got %b want 0000011110", lb_o[0]); end
        rst_n = 1'b1;
        // Start on the very first edge with reset released.
        do_conv(0, 32'd42, 1'b0);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
